gray_pixel_packer: RTL and testbench

Camera-side front end of the grayscale capture path, in the pclk domain. Crops an 8-bit grayscale sensor stream to frame_width × frame_lines and packs pixel pairs into 16-bit words. Each word carries a start-of-frame flag in bit 16, forming the 17-bit pixel_data/pixel_valid stream consumed by ddr3_writer_gray_in. Honors that writer's fifo_almost_full by abandoning overflowed frames cleanly, so the writer re-aligns on the next SOF.

---
 rtl/gray_in_pkg.sv | 13 +
 rtl/gray_pair_packer.sv | 24 ++
 rtl/gray_pixel_packer.sv | 154 +++++++++++++++
 tb/tb_gray_pixel_packer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/gray_in_pkg.sv
// gray_in_pkg: shared state encoding, widths and word-assembly helper for the grayscale capture front end
package gray_in_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_DROP, ST_PAD} state_e;
  localparam int SOF_BIT = 16;
  localparam int PIX_W = 8;
  localparam int WORD_W = 17;
  function automatic logic [WORD_W-1:0] make_word(input logic sof, input logic [2*PIX_W-1:0] pair);
    logic [WORD_W-1:0] w;
    w = WORD_W'(pair);
    w[SOF_BIT] = sof;
    return w;
  endfunction
endpackage

// File: rtl/gray_pair_packer.sv
// gray_pair_packer: holds the even-column pixel and joins it with the next odd-column pixel
//   pclk, pclk_reset_n : clock, async active-low reset
//   pix_ok, col_lsb    : accepted-pixel strobe and column parity of that pixel
//   pix                : pixel value
//   word, word_done    : {odd, even} pair, valid combinationally while word_done is high
module gray_pair_packer
  import gray_in_pkg::*;
(
  input  logic               pclk,
  input  logic               pclk_reset_n,
  input  logic               pix_ok,
  input  logic               col_lsb,
  input  logic [PIX_W-1:0]   pix,
  output logic [2*PIX_W-1:0] word,
  output logic               word_done
);
  logic [PIX_W-1:0] lo_q, lo_d;
  always_comb lo_d = (pix_ok && !col_lsb) ? pix : lo_q;
  always_ff @(posedge pclk or negedge pclk_reset_n)
    if (!pclk_reset_n) lo_q <= '0;
    else lo_q <= lo_d;
  assign word = {pix, lo_q};
  assign word_done = pix_ok && col_lsb;
endmodule

// File: rtl/gray_pixel_packer.sv
// gray_pixel_packer: crops an 8-bit gray stream to frame_width x frame_lines and packs pairs into SOF-tagged 17-bit words
//   pclk, pclk_reset_n           : pixel clock, async active-low reset
//   cam_data/frame_valid/line_valid : sensor stream
//   fifo_almost_full             : writer backpressure; a word completing while high abandons the frame
//   overflow_clear               : clears sticky overflow (a simultaneous new overflow wins)
//   pixel_data, pixel_valid      : {sof, hi, lo} output stream
//   frame_count, overflow, short_frame : status
//   GRAY_PIXEL_PACKER_PAD_EN     : when defined, short frames are zero-padded to a full frame
module gray_pixel_packer
  import gray_in_pkg::*;
#(
  parameter int frame_width = 768,
  parameter int frame_lines = 480
) (
  input  logic              pclk,
  input  logic              pclk_reset_n,
  input  logic [PIX_W-1:0]  cam_data,
  input  logic              cam_frame_valid,
  input  logic              cam_line_valid,
  input  logic              fifo_almost_full,
  input  logic              overflow_clear,
  output logic [WORD_W-1:0] pixel_data,
  output logic              pixel_valid,
  output logic [15:0]       frame_count,
  output logic              overflow,
  output logic              short_frame
);
  localparam int TOTAL_WORDS = frame_width * frame_lines / 2;
  localparam int CW = $clog2(frame_width + 1);
  localparam int LW = $clog2(frame_lines + 1);
  localparam int WCW = $clog2(TOTAL_WORDS + 1);
  localparam logic [CW-1:0] COL_MAX = CW'(frame_width);
  localparam logic [LW-1:0] LINE_MAX = LW'(frame_lines);
  localparam logic [WCW-1:0] WORD_MAX = WCW'(TOTAL_WORDS);
  state_e state_q, state_d;
  logic fv_q, lv_q;
  logic [CW-1:0] col_q, col_d, col_now;
  logic [LW-1:0] line_q, line_d, line_now;
  logic [WCW-1:0] word_cnt_q, word_cnt_d, word_cnt_inc;
  logic sof_pending_q, sof_pending_d;
  logic [WORD_W-1:0] pixel_data_q, pixel_data_d;
  logic pixel_valid_q, pixel_valid_d, short_frame_q, short_frame_d, overflow_q, overflow_d;
  logic [15:0] frame_count_q, frame_count_d;
  logic fv_rise, fv_fall, lv_rise, lv_fall, accept, word_done, frame_start;
  logic [2*PIX_W-1:0] pair_word;
  assign fv_rise = cam_frame_valid && !fv_q;
  assign fv_fall = !cam_frame_valid && fv_q;
  assign lv_rise = cam_line_valid && !lv_q;
  assign lv_fall = !cam_line_valid && lv_q;
  // counters as seen by the pixel on the wire this cycle, with edge resets applied
  assign col_now = (fv_rise || lv_rise) ? '0 : col_q;
  assign line_now = fv_rise ? '0 : line_q;
  assign accept = cam_frame_valid && cam_line_valid && col_now < COL_MAX && line_now < LINE_MAX;
  assign frame_start = fv_rise && (state_q == ST_IDLE || state_q == ST_PAD);
  assign word_cnt_inc = word_cnt_q + WCW'(1);
  gray_pair_packer u_pair (
    .pclk         (pclk),
    .pclk_reset_n (pclk_reset_n),
    .pix_ok       (accept),
    .col_lsb      (col_now[0]),
    .pix          (cam_data),
    .word         (pair_word),
    .word_done    (word_done)
  );
  always_comb begin
    col_d = (cam_line_valid && col_now < COL_MAX) ? col_now + CW'(1) : col_now;
    line_d = fv_rise ? '0 : (lv_fall && line_q < LINE_MAX) ? line_q + LW'(1) : line_q;
    state_d = state_q;
    word_cnt_d = word_cnt_q;
    sof_pending_d = sof_pending_q;
    pixel_data_d = pixel_data_q;
    pixel_valid_d = 1'b0;
    short_frame_d = 1'b0;
    frame_count_d = frame_count_q;
    overflow_d = overflow_clear ? 1'b0 : overflow_q;
    if (frame_start) begin
      state_d = ST_ACTIVE;
      word_cnt_d = '0;
      sof_pending_d = 1'b1;
    end else begin
      case (state_q)
        ST_ACTIVE:
          if (word_done && !fifo_almost_full) begin
            pixel_valid_d = 1'b1;
            pixel_data_d = make_word(sof_pending_q, pair_word);
            sof_pending_d = 1'b0;
            word_cnt_d = word_cnt_inc;
            if (word_cnt_inc == WORD_MAX) begin
              frame_count_d = frame_count_q + 16'd1;
              state_d = ST_IDLE;
            end
          end else if (word_done) begin
            overflow_d = 1'b1;
            state_d = ST_DROP;
          end else if (fv_fall) begin
            short_frame_d = 1'b1;
`ifdef GRAY_PIXEL_PACKER_PAD_EN
            state_d = ST_PAD;
`else
            state_d = ST_IDLE;
`endif
          end
        ST_DROP: state_d = fv_fall ? ST_IDLE : ST_DROP;
`ifdef GRAY_PIXEL_PACKER_PAD_EN
        ST_PAD:
          if (!fifo_almost_full) begin
            pixel_valid_d = 1'b1;
            pixel_data_d = '0;
            word_cnt_d = word_cnt_inc;
            if (word_cnt_inc == WORD_MAX) begin
              frame_count_d = frame_count_q + 16'd1;
              state_d = ST_IDLE;
            end
          end
`endif
        default: ;
      endcase
    end
  end
  // fv_q resets high so a frame already running at reset release never looks like a rising edge
  always_ff @(posedge pclk or negedge pclk_reset_n)
    if (!pclk_reset_n) begin
      state_q <= ST_IDLE;
      fv_q <= 1'b1;
      lv_q <= 1'b0;
      col_q <= '0;
      line_q <= '0;
      word_cnt_q <= '0;
      sof_pending_q <= 1'b0;
      pixel_data_q <= '0;
      pixel_valid_q <= 1'b0;
      short_frame_q <= 1'b0;
      overflow_q <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q <= state_d;
      fv_q <= cam_frame_valid;
      lv_q <= cam_line_valid;
      col_q <= col_d;
      line_q <= line_d;
      word_cnt_q <= word_cnt_d;
      sof_pending_q <= sof_pending_d;
      pixel_data_q <= pixel_data_d;
      pixel_valid_q <= pixel_valid_d;
      short_frame_q <= short_frame_d;
      overflow_q <= overflow_d;
      frame_count_q <= frame_count_d;
    end
  assign pixel_data = pixel_data_q;
  assign pixel_valid = pixel_valid_q;
  assign short_frame = short_frame_q;
  assign overflow = overflow_q;
  assign frame_count = frame_count_q;
endmodule

// File: tb/tb_gray_pixel_packer.sv
// tb_gray_pixel_packer: randomized frames checked against a queue-based model of the crop/pack rules
module tb_gray_pixel_packer;
  localparam int FW = 16;
  localparam int FL = 16;
  localparam int TOTAL = FW * FL / 2;
  logic pclk = 1'b0;
  logic pclk_reset_n = 1'b0;
  logic [7:0] cam_data = '0;
  logic cam_frame_valid = 1'b0, cam_line_valid = 1'b0, fifo_almost_full = 1'b0, overflow_clear = 1'b0;
  logic [16:0] pixel_data;
  logic pixel_valid, overflow, short_frame;
  logic [15:0] frame_count;
  int checks = 0, failures = 0, short_cnt = 0, base = 0;
  logic [16:0] got[$], exp_q[$], sq[$];
  gray_pixel_packer #(.frame_width(FW), .frame_lines(FL)) dut (
    .pclk             (pclk),
    .pclk_reset_n     (pclk_reset_n),
    .cam_data         (cam_data),
    .cam_frame_valid  (cam_frame_valid),
    .cam_line_valid   (cam_line_valid),
    .fifo_almost_full (fifo_almost_full),
    .overflow_clear   (overflow_clear),
    .pixel_data       (pixel_data),
    .pixel_valid      (pixel_valid),
    .frame_count      (frame_count),
    .overflow         (overflow),
    .short_frame      (short_frame)
  );
  always #5 pclk = ~pclk;
  always @(negedge pclk) begin
    if (pixel_valid) got.push_back(pixel_data);
    if (short_frame) short_cnt++;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge pclk);
      #1;
    end
  endtask
  function automatic logic [7:0] pv(input int s, input int l, input int c);
    return (s == 0) ? 8'(c) : 8'(s ^ (l * 53) ^ (c * 29) ^ (s >> (c % 8)));
  endfunction
  // model: accepted pairs in raster order, first flagged SOF, truncated at a dropped word
  task automatic build_exp(input int s, input int nl, input int nw, input int sl, input int dw);
    int lim, wlim;
    lim = nl < FL ? nl : FL;
    if (sl >= 0 && sl < lim) lim = sl;
    wlim = nw < FW ? nw : FW;
    exp_q.delete();
    for (int l = 0; l < lim; l++)
      for (int c = 0; c + 1 < wlim; c += 2)
        if (dw < 0 || exp_q.size() < dw) exp_q.push_back({exp_q.size() == 0, pv(s, l, c + 1), pv(s, l, c)});
  endtask
  task automatic drive_frame(input int s, input int nl, input int nw, input int sl, input int dw, input bit clr, input int rl);
    int wk;
    wk = 0;
    cam_frame_valid = 1'b1;
    tick(2);
    for (int l = 0; l < nl; l++) begin
      if (l == sl) break;
      if (rl >= 0 && l == rl + 1) pclk_reset_n = 1'b1;
      for (int c = 0; c < nw; c++) begin
        cam_line_valid = 1'b1;
        cam_data = pv(s, l, c);
        fifo_almost_full = 1'b0;
        overflow_clear = 1'b0;
        if (l < FL && c < FW && c % 2 == 1) begin
          fifo_almost_full = (wk == dw);
          overflow_clear = clr && (wk == dw);
          wk++;
        end
        tick();
        if (l == rl && c == 5) begin
          pclk_reset_n = 1'b0;
          #1;
          chk("rst_mid_valid", pixel_valid, 0);
          chk("rst_mid_data", pixel_data, 0);
          chk("rst_mid_count", frame_count, 0);
          chk("rst_mid_overflow", overflow, 0);
          base = got.size();
        end
      end
      cam_line_valid = 1'b0;
      fifo_almost_full = 1'b0;
      overflow_clear = 1'b0;
      tick(3);
    end
    cam_frame_valid = 1'b0;
    cam_line_valid = 1'b0;
    tick(3);
  endtask
  task automatic wait_words(input int n, input bit rnd_af);
    int t;
    t = 0;
    while (got.size() - base < n && t < 4000) begin
      if (rnd_af) fifo_almost_full = 1'($urandom_range(0, 1));
      tick();
      t++;
    end
    fifo_almost_full = 1'b0;
    tick(4);
    chk("wait_bound", t < 4000, 1);
  endtask
  task automatic compare_frame(input string tag);
    chk({tag, "_len"}, got.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size() && base + i < got.size(); i++) chk({tag, "_word"}, got[base + i], exp_q[i]);
    base = got.size();
  endtask
  initial begin
    int fc, sc, s, s2, t, i, z;
    fc = 0;
    tick(3);
    chk("rst_valid", pixel_valid, 0);
    chk("rst_data", pixel_data, 0);
    chk("rst_count", frame_count, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_short", short_frame, 0);
    pclk_reset_n = 1'b1;
    tick(2);
    build_exp(0, FL, FW, -1, -1);
    drive_frame(0, FL, FW, -1, -1, 0, -1);
    wait_words(exp_q.size(), 0);
    chk("a_first", got[base], 17'h10100);
    compare_frame("a");
    fc++;
    chk("a_fc", frame_count, fc);
    build_exp(0, FL + 2, FW + 4, -1, -1);
    drive_frame(0, FL + 2, FW + 4, -1, -1, 0, -1);
    wait_words(exp_q.size(), 0);
    chk("b_crop_edge", got[base + 7], 17'h00F0E);
    compare_frame("b");
    fc++;
    chk("b_fc", frame_count, fc);
    s = int'($urandom_range(1, 1000000));
    sc = short_cnt;
    build_exp(s, FL, FW, -1, 50);
    drive_frame(s, FL, FW, -1, 50, 0, -1);
    wait_words(50, 0);
    compare_frame("c");
    chk("c_overflow", overflow, 1);
    chk("c_fc", frame_count, fc);
    chk("c_no_short", short_cnt, sc);
    s = int'($urandom_range(1, 1000000));
    build_exp(s, FL, FW, -1, -1);
    drive_frame(s, FL, FW, -1, -1, 0, -1);
    wait_words(exp_q.size(), 0);
    chk("d_sof", got[base][16], 1);
    compare_frame("d");
    fc++;
    chk("d_fc", frame_count, fc);
    chk("d_sticky", overflow, 1);
    overflow_clear = 1'b1;
    tick();
    overflow_clear = 1'b0;
    chk("d_cleared", overflow, 0);
    s = int'($urandom_range(1, 1000000));
    build_exp(s, FL, FW, -1, 5);
    drive_frame(s, FL, FW, -1, 5, 1, -1);
    wait_words(5, 0);
    compare_frame("e");
    chk("e_set_wins", overflow, 1);
    s = int'($urandom_range(1, 1000000));
    sc = short_cnt;
    build_exp(s, FL, FW, 4, -1);
`ifdef GRAY_PIXEL_PACKER_PAD_EN
    repeat (TOTAL - exp_q.size()) exp_q.push_back('0);
    fc++;
`endif
    drive_frame(s, FL, FW, 4, -1, 0, -1);
    wait_words(exp_q.size(), 1);
    compare_frame("f");
    chk("f_fc", frame_count, fc);
    chk("f_short", short_cnt, sc + 1);
    s = int'($urandom_range(1, 1000000));
    drive_frame(s, FL, FW, -1, -1, 0, 3);
    tick(4);
    chk("g_silent", got.size() - base, 0);
    chk("g_fc", frame_count, 0);
    base = got.size();
    fc = 0;
    s = int'($urandom_range(1, 1000000));
    build_exp(s, FL, FW, -1, -1);
    drive_frame(s, FL, FW, -1, -1, 0, -1);
    wait_words(exp_q.size(), 0);
    chk("g_sof", got[base][16], 1);
    compare_frame("g");
    fc++;
    chk("g_fc_after", frame_count, fc);
    s = int'($urandom_range(1, 1000000));
    s2 = int'($urandom_range(1, 1000000));
    sc = short_cnt;
    build_exp(s, FL, FW, 4, -1);
    sq = exp_q;
    drive_frame(s, FL, FW, 4, -1, 0, -1);
    drive_frame(s2, FL, FW, -1, -1, 0, -1);
    build_exp(s2, FL, FW, -1, -1);
    t = 0;
    while (frame_count != 16'(fc + 1) && t < 6000) begin
      tick();
      t++;
    end
    chk("h_bound", t < 6000, 1);
    tick(4);
    fc++;
    i = base;
    for (int k = 0; k < sq.size(); k++) begin
      chk("h_short_word", got[i], sq[k]);
      i++;
    end
    z = 0;
    while (i < got.size() && got[i] == 17'h0) begin
      z++;
      i++;
    end
`ifdef GRAY_PIXEL_PACKER_PAD_EN
    chk("h_pad_partial", z > 0 && z < TOTAL - sq.size(), 1);
`else
    chk("h_no_pad", z, 0);
`endif
    chk("h_len", got.size() - i, exp_q.size());
    chk("h_sof", got[i][16], 1);
    for (int k = 0; k < exp_q.size() && i + k < got.size(); k++) chk("h_new_word", got[i + k], exp_q[k]);
    base = got.size();
    chk("h_short", short_cnt, sc + 1);
    chk("h_fc", frame_count, fc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
